sync_tx: RTL and testbench

SYNC_TX -- requirements
Module: sync_tx

---
 rtl/sync_tx.sv | 137 +++++++++++++
 tb/tb_sync_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_tx.sv
// Framed serial transmitter: 0101 sync preamble, MSB-first payload, even parity,
// then GAP_BITS idle-level bits. All outputs come straight from flops.
module sync_tx #(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int WIDEST = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
  localparam int MAXB   = (WIDEST > 4) ? WIDEST : 4;
  localparam int CW     = $clog2(MAXB);

  localparam logic [CW-1:0] SYNC_LAST = CW'(3);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PARITY,
    S_GAP
  } state_t;

  state_t            r_state, w_state_n;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic [DATA_W-1:0] r_shreg, w_shreg_n, w_shl;
  logic              r_par, w_par_n;
  logic              r_dout, w_dout_n;
  logic              r_busy, w_busy_n;
  logic              r_done, w_done_n;

  assign w_shl = r_shreg << 1;

  // Outputs are computed for the next state and registered, so the line value
  // appears in the same cycle the FSM enters the corresponding state.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_shreg_n = r_shreg;
    w_par_n   = r_par;
    w_dout_n  = r_dout;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dout_n = 1'b1;
        w_busy_n = 1'b0;
        if (start) begin
          w_state_n = S_SYNC;
          w_cnt_n   = '0;
          w_shreg_n = data_in;
          w_par_n   = ^data_in;
          w_dout_n  = 1'b0;
          w_busy_n  = 1'b1;
        end
      end
      S_SYNC: begin
        if (r_cnt == SYNC_LAST) begin
          w_state_n = S_DATA;
          w_cnt_n   = '0;
          w_dout_n  = r_shreg[DATA_W-1];
        end else begin
          w_cnt_n  = r_cnt + CNT_ONE;
          // Preamble alternates, so each bit is the inverse of the previous one.
          w_dout_n = ~r_dout;
        end
      end
      S_DATA: begin
        w_shreg_n = w_shl;
        if (r_cnt == DATA_LAST) begin
          w_state_n = S_PARITY;
          w_cnt_n   = '0;
          w_dout_n  = r_par;
        end else begin
          w_cnt_n  = r_cnt + CNT_ONE;
          w_dout_n = w_shl[DATA_W-1];
        end
      end
      S_PARITY: begin
        w_state_n = S_GAP;
        w_cnt_n   = '0;
        w_dout_n  = 1'b1;
      end
      S_GAP: begin
        w_dout_n = 1'b1;
        if (r_cnt == GAP_LAST) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
        end else begin
          w_cnt_n = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
        w_dout_n  = 1'b1;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_par   <= 1'b0;
      r_dout  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_shreg <= w_shreg_n;
      r_par   <= w_par_n;
      r_dout  <= w_dout_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  assign dout = r_dout;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_sync_tx.sv
// Bench for sync_tx: frame-level reference model checked every cycle, directed
// literal frames, and a randomized start/data/reset phase.
module tb_sync_tx;

  localparam int FLEN = 15;

  logic       clk = 1'b0;
  logic       rst, start, start2;
  logic [7:0] data_in;
  logic [3:0] din2;
  logic       dout, busy, done;
  logic       dout2, busy2, done2;

  int total = 0;
  int bad   = 0;

  sync_tx dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .dout(dout), .busy(busy), .done(done)
  );

  sync_tx #(.DATA_W(4), .GAP_BITS(1)) dut4 (
    .clk(clk), .rst(rst), .start(start2), .data_in(din2),
    .dout(dout2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line bits; position -1 means idle.
  logic m_bits [0:FLEN-1];
  int   m_pos  = -1;
  logic m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos  <= -1;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_pos >= 0) begin
        if (m_pos + 1 == FLEN) begin
          m_pos  <= -1;
          m_done <= 1'b1;
        end else begin
          m_pos <= m_pos + 1;
        end
      end else if (start) begin
        m_bits[0] <= 1'b0;
        m_bits[1] <= 1'b1;
        m_bits[2] <= 1'b0;
        m_bits[3] <= 1'b1;
        for (int k = 0; k < 8; k++) m_bits[4+k] <= data_in[7-k];
        m_bits[12] <= ^data_in;
        m_bits[13] <= 1'b1;
        m_bits[14] <= 1'b1;
        m_pos <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_dout", dout, (m_pos < 0) ? 1'b1 : m_bits[m_pos]);
    chk("model_busy", busy, (m_pos >= 0) ? 1 : 0);
    chk("model_done", done, m_done);
  end

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    start   = 1'b1;
    data_in = d;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Called at the negedge of the first sync cycle; returns at the done cycle.
  task automatic check_frame(input logic [14:0] pat, input int poke, input logic [7:0] pdata);
    for (int i = 0; i < FLEN; i++) begin
      if (poke != 0 && i + 1 == poke) begin
        start   = 1'b1;
        data_in = pdata;
      end else if (poke != 0 && i == poke) begin
        start = 1'b0;
      end
      chk("frame_dout", dout, pat[14-i]);
      chk("frame_busy", busy, 1);
      chk("frame_done", done, 0);
      @(negedge clk);
    end
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_dout", dout, 1);
  endtask

  logic [14:0] pA5, p07, p3C;
  logic [9:0]  pB4;

  initial begin
    pA5 = 15'b0101_10100101_0_11;
    p07 = 15'b0101_00000111_1_11;
    p3C = 15'b0101_00111100_0_11;
    pB4 = 10'b0101_1011_1_1;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; data_in = '0; din2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout4", dout2, 1);
    rst = 1'b0;

    // Narrow instance: 4-bit payload, single gap bit.
    @(negedge clk);
    start2 = 1'b1; din2 = 4'hB;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("w4_dout", dout2, pB4[9-i]);
      chk("w4_busy", busy2, 1);
      @(negedge clk);
    end
    chk("w4_done", done2, 1);
    chk("w4_idle", busy2, 0);
    @(negedge clk);
    chk("w4_done_off", done2, 0);

    send(8'hA5);
    check_frame(pA5, 0, 8'h00);
    @(negedge clk);
    chk("pulse_width", done, 0);

    send(8'h07);
    check_frame(p07, 0, 8'h00);

    // Start held high: frames back to back, re-accepted in the done cycle.
    @(negedge clk);
    start = 1'b1; data_in = 8'h3C;
    @(negedge clk);
    check_frame(p3C, 0, 8'h00);
    @(negedge clk);
    check_frame(p3C, 0, 8'h00);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_stop", busy, 0);

    // Start during a frame is ignored and not queued.
    send(8'hA5);
    check_frame(pA5, 5, 8'h3C);
    repeat (3) begin
      @(negedge clk);
      chk("no_queue", busy, 0);
    end

    // Async reset in DATA bit 3, with start held during reset.
    send(8'hA5);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_dout", dout, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    start = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
    end
    send(8'h07);
    check_frame(p07, 0, 8'h00);

    // Randomized phase, model-checked each cycle.
    repeat (600) begin
      @(negedge clk);
      rst     = 1'b0;
      start   = ($urandom_range(0, 3) == 0);
      data_in = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #3 rst = 1'b1;
        #1;
        chk("rand_arst_dout", dout, 1);
        chk("rand_arst_busy", busy, 0);
      end
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
